// File: rtl/i2s_clkws_pkg.sv
// Shared types and the word-select rule for the I2S/TDM clock generators.
package i2s_clkws_pkg;

  // Word-select framing modes; encoding 3 behaves as ALT.
  typedef enum logic [1:0] {
    WS_ALT   = 2'd0,
    WS_PULSE = 2'd1,
    WS_WORD  = 2'd2
  } ws_mode_e;

  // Generator run state.
  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  // Word-select level for a (slot, bit) position, given only the bits of the
  // position that matter so the function stays width-independent.
  function automatic logic ws_of(input logic [1:0] mode,
                                 input logic       slot_zero,
                                 input logic       slot_lsb,
                                 input logic       bit_zero);
    case (mode)
      WS_PULSE: return slot_zero & bit_zero;
      WS_WORD:  return slot_zero;
      default:  return slot_lsb;
    endcase
  endfunction

endpackage

// File: rtl/i2s_clkws_tdm_ch.sv
// One SCK/WS generator with TDM slot counting and frame-boundary config shadowing.
module i2s_clkws_tdm_ch
  import i2s_clkws_pkg::*;
#(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned SIZE_W = 5,
  parameter int unsigned NUM_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sync,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [SIZE_W-1:0] cfg_word_size,
  input  logic [NUM_W-1:0]  cfg_word_num,
  input  logic [1:0]        cfg_ws_mode,
  input  logic              cfg_ws_dly,
  output logic              sck,
  output logic              sck_rise,
  output logic              sck_fall,
  output logic              ws,
  output logic              frame,
  output logic [NUM_W-1:0]  slot,
  output logic [SIZE_W-1:0] bit_idx
);

  ch_state_e         state_q, state_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0]  div_sh_q, div_sh_d;
  logic [SIZE_W-1:0] size_sh_q, size_sh_d;
  logic [NUM_W-1:0]  num_sh_q, num_sh_d;
  logic [1:0]        mode_sh_q, mode_sh_d;
  logic              dly_sh_q, dly_sh_d;
  logic              sck_q, sck_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              ws_q, ws_d;
  logic              frame_q, frame_d;
  logic [NUM_W-1:0]  slot_q, slot_d;
  logic [SIZE_W-1:0] bit_q, bit_d;
  logic              pos_load;

  // WS for a position; with the lead enabled, look one bit ahead with frame wrap.
  function automatic logic ws_at(input logic [1:0]        mode,
                                 input logic              dly,
                                 input logic [NUM_W-1:0]  s,
                                 input logic [SIZE_W-1:0] b,
                                 input logic [NUM_W-1:0]  num,
                                 input logic [SIZE_W-1:0] size);
    logic [NUM_W-1:0]  ns;
    logic [SIZE_W-1:0] nb;
    ns = s;
    nb = b;
    if (dly) begin
      if (b == size) begin
        nb = '0;
        ns = (s == num) ? '0 : s + 1'b1;
      end else begin
        nb = b + 1'b1;
      end
    end
    return ws_of(mode, ns == '0, ns[0], nb == '0);
  endfunction

  // Next-state: disable beats realign/start, which beats normal counting.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    div_sh_d  = div_sh_q;
    size_sh_d = size_sh_q;
    num_sh_d  = num_sh_q;
    mode_sh_d = mode_sh_q;
    dly_sh_d  = dly_sh_q;
    sck_d     = sck_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    ws_d      = ws_q;
    frame_d   = 1'b0;
    slot_d    = slot_q;
    bit_d     = bit_q;
    pos_load  = 1'b0;

    if (!en) begin
      state_d   = CH_IDLE;
      div_cnt_d = '0;
      sck_d     = 1'b0;
      ws_d      = 1'b0;
      slot_d    = '0;
      bit_d     = '0;
    end else if (sync || state_q == CH_IDLE) begin
      state_d   = CH_RUN;
      div_sh_d  = cfg_div;
      size_sh_d = cfg_word_size;
      num_sh_d  = cfg_word_num;
      mode_sh_d = cfg_ws_mode;
      dly_sh_d  = cfg_ws_dly;
      div_cnt_d = '0;
      sck_d     = 1'b0;
      slot_d    = '0;
      bit_d     = '0;
      frame_d   = 1'b1;
      pos_load  = 1'b1;
    end else if (div_cnt_q == div_sh_q) begin
      div_cnt_d = '0;
      sck_d     = ~sck_q;
      if (!sck_q) begin
        rise_d = 1'b1;
      end else begin
        fall_d   = 1'b1;
        pos_load = 1'b1;
        if (bit_q == size_sh_q) begin
          bit_d = '0;
          if (slot_q == num_sh_q) begin
            slot_d    = '0;
            frame_d   = 1'b1;
            div_sh_d  = cfg_div;
            size_sh_d = cfg_word_size;
            num_sh_d  = cfg_word_num;
            mode_sh_d = cfg_ws_mode;
            dly_sh_d  = cfg_ws_dly;
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end

    // WS is recomputed only when the position moves; at a frame boundary it
    // already reflects the freshly loaded shadow config.
    if (pos_load) begin
      ws_d = ws_at(mode_sh_d, dly_sh_d, slot_d, bit_d, num_sh_d, size_sh_d);
    end
  end

  // State, shadow and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CH_IDLE;
      div_cnt_q <= '0;
      div_sh_q  <= '0;
      size_sh_q <= '0;
      num_sh_q  <= '0;
      mode_sh_q <= '0;
      dly_sh_q  <= 1'b0;
      sck_q     <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      ws_q      <= 1'b0;
      frame_q   <= 1'b0;
      slot_q    <= '0;
      bit_q     <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      div_sh_q  <= div_sh_d;
      size_sh_q <= size_sh_d;
      num_sh_q  <= num_sh_d;
      mode_sh_q <= mode_sh_d;
      dly_sh_q  <= dly_sh_d;
      sck_q     <= sck_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      ws_q      <= ws_d;
      frame_q   <= frame_d;
      slot_q    <= slot_d;
      bit_q     <= bit_d;
    end
  end

  assign sck      = sck_q;
  assign sck_rise = rise_q;
  assign sck_fall = fall_q;
  assign ws       = ws_q;
  assign frame    = frame_q;
  assign slot     = slot_q;
  assign bit_idx  = bit_q;

endmodule

// File: rtl/i2s_clkws_tdm_gen.sv
// NUM_GEN independent I2S/TDM SCK/WS generators sharing one realign strobe.
module i2s_clkws_tdm_gen
  import i2s_clkws_pkg::*;
#(
  parameter int unsigned NUM_GEN = 2,
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned SIZE_W  = 5,
  parameter int unsigned NUM_W   = 3
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [NUM_GEN-1:0]        en_i,
  input  logic                      sync_i,
  input  logic [NUM_GEN*DIV_W-1:0]  cfg_div_i,
  input  logic [NUM_GEN*SIZE_W-1:0] cfg_word_size_i,
  input  logic [NUM_GEN*NUM_W-1:0]  cfg_word_num_i,
  input  logic [NUM_GEN*2-1:0]      cfg_ws_mode_i,
  input  logic [NUM_GEN-1:0]        cfg_ws_dly_i,
  output logic [NUM_GEN-1:0]        sck_o,
  output logic [NUM_GEN-1:0]        sck_rise_o,
  output logic [NUM_GEN-1:0]        sck_fall_o,
  output logic [NUM_GEN-1:0]        ws_o,
  output logic [NUM_GEN-1:0]        frame_o,
  output logic [NUM_GEN*NUM_W-1:0]  slot_o,
  output logic [NUM_GEN*SIZE_W-1:0] bit_o
);

  // One generator per slice of the packed config/status vectors.
  for (genvar g = 0; g < NUM_GEN; g++) begin : g_ch
    i2s_clkws_tdm_ch #(
      .DIV_W (DIV_W),
      .SIZE_W(SIZE_W),
      .NUM_W (NUM_W)
    ) u_ch (
      .clk          (clk_i),
      .rst_n        (rstn_i),
      .en           (en_i[g]),
      .sync         (sync_i),
      .cfg_div      (cfg_div_i[g*DIV_W +: DIV_W]),
      .cfg_word_size(cfg_word_size_i[g*SIZE_W +: SIZE_W]),
      .cfg_word_num (cfg_word_num_i[g*NUM_W +: NUM_W]),
      .cfg_ws_mode  (cfg_ws_mode_i[g*2 +: 2]),
      .cfg_ws_dly   (cfg_ws_dly_i[g]),
      .sck          (sck_o[g]),
      .sck_rise     (sck_rise_o[g]),
      .sck_fall     (sck_fall_o[g]),
      .ws           (ws_o[g]),
      .frame        (frame_o[g]),
      .slot         (slot_o[g*NUM_W +: NUM_W]),
      .bit_idx      (bit_o[g*SIZE_W +: SIZE_W])
    );
  end

endmodule
